paddle_sched: RTL and testbench
===============================

PADDLE_SCHED -- requirements
Module: paddle_sched

Interface
REQ-001 Parameter STEP_SLOW, default 5, digital paddle movement per frame when speed=0.
REQ-002 Parameter STEP_FAST, default 8, digital paddle movement per frame when speed=1.
REQ-003 Parameter CENTER, default 128, reset value of each digital position register.
REQ-004 clk_sys  in  1  system clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 vs  in  1  active-high vertical sync from the video chip; a rising edge marks a frame start.
REQ-007 hs  in  1  active-high horizontal sync; a rising edge marks a line.
REQ-008 speed  in  1  selects STEP_FAST (1) or STEP_SLOW (0).
REQ-009 p1_mode, p2_mode  in  2 each  source select: 0 digital, 1 analog Y, 2 analog X, 3 paddle.
REQ-010 p1_invert, p2_invert  in  1 each  XOR the selected 8-bit value with 8'hFF.
REQ-011 p1_up, p1_down, p2_up, p2_down  in  1 each  digital movement requests, level-sensitive.
REQ-012 analog_0, analog_1  in  16 each  signed stick values: [15:8] Y, [7:0] X.
REQ-013 paddle_0, paddle_1  in  8 each  unsigned paddle positions.
REQ-014 practice  in  1  when 1, rp_in mirrors lp_in.
REQ-015 lp_in, rp_in  out  1 each  pot-comparator inputs to the video chip; high once the player's line count has expired.

Function
REQ-016 Edge detect: registered vs_d and hs_d; vs_rise = vs & ~vs_d; hs_rise = hs & ~hs_d.
REQ-017 Each player runs an independent FSM over states WAIT, COUNT and HOLD, with a 9-bit count register cnt.
REQ-018 Source value sel: digital = pos[7:0]; Y = {~a[15], a[14:8]}; X = {~a[7], a[6:0]}; paddle = paddle byte; then XOR 8'hFF when invert=1.
REQ-019 On vs_rise in any state: cnt <= {1'b0, sel}; next state is HOLD if sel==0, otherwise COUNT.
REQ-020 On hs_rise in COUNT with vs_rise=0: cnt <= cnt-1; if cnt==1 the next state is HOLD.
REQ-021 hs_rise is ignored in WAIT and HOLD; cnt never decrements below 0.
REQ-022 Simultaneous vs_rise and hs_rise: the vs_rise action alone applies; no decrement that cycle.
REQ-023 A vs_rise while in COUNT (count not yet expired) reloads cnt; no fire pulse is generated.
REQ-024 Output decode: lp_in = (P1 state==HOLD); rp_in = practice ? lp_in : (P2 state==HOLD); decoded from registered state only.
REQ-025 Digital position pos is 9-bit and updates only on vs_rise, only when that player's mode==0.
REQ-026 The load uses the pre-update pos, so a digital move is reflected in the next frame (one-frame latency).
REQ-027 Digital move, step = speed ? STEP_FAST : STEP_SLOW:
- up: pos <= (pos < step) ? 0 : pos-step.
- down: pos <= (pos+step > 255) ? 255 : pos+step.
REQ-028 When up and down are both asserted, down wins.
REQ-029 pos holds its value while the mode is non-digital and resumes from that value when the mode returns to 0.
REQ-030 Mode or invert changes take effect at the next vs_rise; a count already in progress is unaffected.

Reset
REQ-031 While reset=0: both states = WAIT, cnt=0, pos=CENTER, vs_d=0, hs_d=0, lp_in=0, rp_in=0 (rp_in=lp_in=0 when practice=1).
REQ-032 Reset asserted mid-COUNT aborts immediately to WAIT; the first vs_rise after release restarts normal operation.

Verification
REQ-033 Reset, P1 digital, no buttons, invert=0: vs pulse, then 127 hs pulses -> lp_in=0; 128th hs pulse -> lp_in=1 on the following cycle.
REQ-034 P1 digital, speed=1, p1_up held across 20 vs pulses -> pos sequence 120, 112, ... saturates at 0; the next frame's load gives sel=0 and lp_in=1 directly after vs_rise.
REQ-035 P2 mode=1, analog_1[15:8]=8'h80, invert=1: sel = 8'h00^8'hFF = 255 -> rp_in rises after 255 hs pulses.
REQ-036 vs and hs rising on the same cycle with cnt=5 in COUNT -> cnt reloads to sel with no decrement; HOLD is entered only after sel further hs pulses.
REQ-037 practice=1, P1 paddle_0=10, P2 paddle_1=200 -> rp_in equals lp_in every cycle, rising after 10 hs pulses.
REQ-038 Reset pulsed low after 50 of 100 hs pulses -> lp_in=0 and WAIT held until the next vs_rise; pos=128.

Source files
------------

// File: rtl/paddle_sched.sv
// Two-player paddle/pot scheduler: per frame, each player loads a line count from
// the selected input source and raises its pot-comparator input once it expires.
module paddle_sched #(
  parameter int STEP_SLOW = 5,
  parameter int STEP_FAST = 8,
  parameter int CENTER    = 128
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        vs,
  input  logic        hs,
  input  logic        speed,
  input  logic [1:0]  p1_mode,
  input  logic [1:0]  p2_mode,
  input  logic        p1_invert,
  input  logic        p2_invert,
  input  logic        p1_up,
  input  logic        p1_down,
  input  logic        p2_up,
  input  logic        p2_down,
  input  logic [15:0] analog_0,
  input  logic [15:0] analog_1,
  input  logic [7:0]  paddle_0,
  input  logic [7:0]  paddle_1,
  input  logic        practice,
  output logic        lp_in,
  output logic        rp_in
);

  localparam logic [1:0] ST_WAIT  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [8:0] STEP_SLOW_V = 9'(STEP_SLOW);
  localparam logic [8:0] STEP_FAST_V = 9'(STEP_FAST);
  localparam logic [8:0] CENTER_V    = 9'(CENTER);

  // Analog bytes are signed; flipping the MSB maps them onto an unsigned line count.
  function automatic logic [7:0] src_sel(input logic [1:0] mode, input logic inv,
                                         input logic [8:0] pos, input logic [15:0] a,
                                         input logic [7:0] pad);
    logic [7:0] v;
    case (mode)
      2'd0:    v = pos[7:0];
      2'd1:    v = {~a[15], a[14:8]};
      2'd2:    v = {~a[7], a[6:0]};
      2'd3:    v = pad;
      default: v = 8'h00;
    endcase
    return inv ? (v ^ 8'hFF) : v;
  endfunction

  function automatic logic [8:0] pos_next(input logic [8:0] pos, input logic up,
                                          input logic down, input logic [8:0] step);
    logic [9:0] sum;
    sum = {1'b0, pos} + {1'b0, step};
    if (down) begin
      return (sum > 10'd255) ? 9'd255 : sum[8:0];
    end else if (up) begin
      return (pos < step) ? 9'd0 : (pos - step);
    end else begin
      return pos;
    end
  endfunction

  logic        vs_q, hs_q;
  logic        vs_rise_s, hs_rise_s;
  logic [8:0]  step_s;
  logic [1:0]  mode_s   [2];
  logic        inv_s    [2];
  logic        up_s     [2];
  logic        down_s   [2];
  logic [15:0] analog_s [2];
  logic [7:0]  paddle_s [2];
  logic [7:0]  sel_s    [2];
  logic [1:0]  state_q  [2];
  logic [1:0]  state_d  [2];
  logic [8:0]  cnt_q    [2];
  logic [8:0]  cnt_d    [2];
  logic [8:0]  pos_q    [2];
  logic [8:0]  pos_d    [2];

  assign vs_rise_s = vs & ~vs_q;
  assign hs_rise_s = hs & ~hs_q;
  assign step_s    = speed ? STEP_FAST_V : STEP_SLOW_V;

  assign mode_s[0]   = p1_mode;
  assign mode_s[1]   = p2_mode;
  assign inv_s[0]    = p1_invert;
  assign inv_s[1]    = p2_invert;
  assign up_s[0]     = p1_up;
  assign up_s[1]     = p2_up;
  assign down_s[0]   = p1_down;
  assign down_s[1]   = p2_down;
  assign analog_s[0] = analog_0;
  assign analog_s[1] = analog_1;
  assign paddle_s[0] = paddle_0;
  assign paddle_s[1] = paddle_1;

  // Per-player next state; a frame start overrides any same-cycle line pulse.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sel_s[i]   = src_sel(mode_s[i], inv_s[i], pos_q[i], analog_s[i], paddle_s[i]);
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      pos_d[i]   = pos_q[i];
      if (vs_rise_s) begin
        cnt_d[i]   = {1'b0, sel_s[i]};
        state_d[i] = (sel_s[i] == 8'd0) ? ST_HOLD : ST_COUNT;
        if (mode_s[i] == 2'd0) begin
          pos_d[i] = pos_next(pos_q[i], up_s[i], down_s[i], step_s);
        end else begin
          pos_d[i] = pos_q[i];
        end
      end else if (hs_rise_s && (state_q[i] == ST_COUNT)) begin
        if (cnt_q[i] <= 9'd1) begin
          cnt_d[i]   = 9'd0;
          state_d[i] = ST_HOLD;
        end else begin
          cnt_d[i]   = cnt_q[i] - 9'd1;
          state_d[i] = ST_COUNT;
        end
      end else begin
        state_d[i] = state_q[i];
      end
    end
  end

  // State, count, position and sync-history registers.
  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      vs_q <= 1'b0;
      hs_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= ST_WAIT;
        cnt_q[i]   <= 9'd0;
        pos_q[i]   <= CENTER_V;
      end
    end else begin
      vs_q <= vs;
      hs_q <= hs;
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        pos_q[i]   <= pos_d[i];
      end
    end
  end

  assign lp_in = (state_q[0] == ST_HOLD);
  assign rp_in = practice ? lp_in : (state_q[1] == ST_HOLD);

endmodule

// File: tb/tb_paddle_sched.sv
// Directed self-checking bench for paddle_sched.
module tb_paddle_sched;

  logic        clk_sys = 1'b0;
  logic        reset, vs, hs, speed, practice;
  logic [1:0]  p1_mode, p2_mode;
  logic        p1_invert, p2_invert, p1_up, p1_down, p2_up, p2_down;
  logic [15:0] analog_0, analog_1;
  logic [7:0]  paddle_0, paddle_1;
  logic        lp_in, rp_in;
  int          checks = 0;
  int          errors = 0;

  paddle_sched dut (
    .clk_sys(clk_sys), .reset(reset), .vs(vs), .hs(hs), .speed(speed),
    .p1_mode(p1_mode), .p2_mode(p2_mode), .p1_invert(p1_invert), .p2_invert(p2_invert),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .analog_0(analog_0), .analog_1(analog_1), .paddle_0(paddle_0), .paddle_1(paddle_1),
    .practice(practice), .lp_in(lp_in), .rp_in(rp_in)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic pulse_vs();
    vs = 1'b1; cyc();
    vs = 1'b0; cyc();
  endtask

  task automatic pulse_hs(input int n);
    for (int k = 0; k < n; k++) begin
      hs = 1'b1; cyc();
      hs = 1'b0; cyc();
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; cyc(); cyc();
    reset = 1'b1; cyc();
  endtask

  initial begin
    reset = 1'b1; vs = 1'b0; hs = 1'b0; speed = 1'b0; practice = 1'b0;
    p1_mode = 2'd0; p2_mode = 2'd0; p1_invert = 1'b0; p2_invert = 1'b0;
    p1_up = 1'b0; p1_down = 1'b0; p2_up = 1'b0; p2_down = 1'b0;
    analog_0 = 16'h0000; analog_1 = 16'h0000; paddle_0 = 8'd0; paddle_1 = 8'd0;
    #2;

    // Reset values
    reset = 1'b0; cyc();
    chk("rst_lp", lp_in, 1'b0);
    chk("rst_rp", rp_in, 1'b0);
    practice = 1'b1; #1;
    chk("rst_rp_practice", rp_in, 1'b0);
    practice = 1'b0;
    reset = 1'b1; cyc();
    pulse_hs(3);
    chk("wait_ignores_hs", lp_in, 1'b0);

    // P1 digital centre: 128 lines
    pulse_vs();
    pulse_hs(127);
    chk("center_127", lp_in, 1'b0);
    pulse_hs(1);
    chk("center_128", lp_in, 1'b1);
    pulse_hs(5);
    chk("hold_ignores_hs", lp_in, 1'b1);

    // Fast up held: loads 128,120,...,8 then 0 from frame 17 on
    do_reset();
    speed = 1'b1; p1_up = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      pulse_vs();
      chk($sformatf("up_frame%0d", n), lp_in, (n >= 17) ? 1'b1 : 1'b0);
    end
    p1_up = 1'b0;

    // Three fast up steps -> pos 104, seen on the following frame
    do_reset();
    p1_up = 1'b1;
    pulse_vs(); pulse_vs(); pulse_vs();
    p1_up = 1'b0;
    pulse_vs();
    pulse_hs(103);
    chk("pos104_103", lp_in, 1'b0);
    pulse_hs(1);
    chk("pos104_104", lp_in, 1'b1);

    // Up+down slow: down wins -> 133
    do_reset();
    speed = 1'b0; p1_up = 1'b1; p1_down = 1'b1;
    pulse_vs();
    p1_up = 1'b0; p1_down = 1'b0;
    pulse_vs();
    pulse_hs(132);
    chk("downwins_132", lp_in, 1'b0);
    pulse_hs(1);
    chk("downwins_133", lp_in, 1'b1);

    // Fast down saturates at 255; invert turns it into 0
    do_reset();
    speed = 1'b1; p1_down = 1'b1;
    for (int n = 0; n < 17; n++) pulse_vs();
    p1_down = 1'b0; p1_invert = 1'b1;
    pulse_vs();
    chk("sat255_inverted_zero", lp_in, 1'b1);
    p1_invert = 1'b0;
    pulse_vs();
    pulse_hs(254);
    chk("sat255_254", lp_in, 1'b0);
    pulse_hs(1);
    chk("sat255_255", lp_in, 1'b1);

    // P2 analog Y 0x80 inverted -> 255
    do_reset();
    p2_mode = 2'd1; p2_invert = 1'b1; analog_1 = 16'h8000;
    pulse_vs();
    pulse_hs(254);
    chk("p2_analogy_254", rp_in, 1'b0);
    pulse_hs(1);
    chk("p2_analogy_255", rp_in, 1'b1);
    p2_mode = 2'd0; p2_invert = 1'b0; analog_1 = 16'h0000;

    // P1 analog X 0x85 -> 5
    do_reset();
    p1_mode = 2'd2; analog_0 = 16'h0085;
    pulse_vs();
    pulse_hs(4);
    chk("p1_analogx_4", lp_in, 1'b0);
    pulse_hs(1);
    chk("p1_analogx_5", lp_in, 1'b1);
    p1_mode = 2'd0; analog_0 = 16'h0000;

    // Simultaneous vs/hs with cnt=5: reload to 128, no decrement
    do_reset();
    pulse_vs();
    pulse_hs(123);
    vs = 1'b1; hs = 1'b1; cyc();
    vs = 1'b0; hs = 1'b0; cyc();
    chk("vs_hs_reload", lp_in, 1'b0);
    pulse_hs(127);
    chk("vs_hs_127", lp_in, 1'b0);
    pulse_hs(1);
    chk("vs_hs_128", lp_in, 1'b1);

    // Practice: rp mirrors lp (paddles 10 / 200)
    do_reset();
    practice = 1'b1; p1_mode = 2'd3; p2_mode = 2'd3; paddle_0 = 8'd10; paddle_1 = 8'd200;
    pulse_vs();
    for (int k = 1; k <= 12; k++) begin
      pulse_hs(1);
      chk($sformatf("practice_lp%0d", k), lp_in, (k >= 10) ? 1'b1 : 1'b0);
      chk($sformatf("practice_rp%0d", k), rp_in, (k >= 10) ? 1'b1 : 1'b0);
    end
    practice = 1'b0; #1;
    chk("practice_off_rp", rp_in, 1'b0);

    // Reset mid-count aborts to WAIT; pos back to 128
    do_reset();
    p2_mode = 2'd0; p1_mode = 2'd3; paddle_0 = 8'd100;
    pulse_vs();
    pulse_hs(50);
    reset = 1'b0; cyc();
    chk("midreset_lp", lp_in, 1'b0);
    reset = 1'b1; cyc();
    pulse_hs(60);
    chk("midreset_wait", lp_in, 1'b0);
    p1_mode = 2'd0;
    pulse_vs();
    pulse_hs(127);
    chk("midreset_pos_127", lp_in, 1'b0);
    pulse_hs(1);
    chk("midreset_pos_128", lp_in, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
